// File: rtl/dht_scheduler.sv
// dht_scheduler
// Read scheduler for up to N = 2**ADDR_W DHT11 sensors. Decoded one-shot,
// continuous and stop requests mark sensors as pending and/or continuous.
// Only one sensor reader is enabled at a time. Each sensor has its own
// minimum gap between reads, and every read is bounded by a timeout. Each
// result is offered downstream over a valid/ready handshake.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   req_valid/addr        one-cycle request strobe and target sensor
//   req_cont, req_stop    enter / leave continuous mode (stop wins)
//   dht_en                one-hot enable to the sensor readers
//   dht_done, dht_error   per-sensor completion pulse and error flag
//   rd_valid/ready        result handshake
//   rd_addr, rd_error,    result sensor, failure flag, timeout flag
//   rd_timeout
//   cont_mask             sensors currently in continuous mode
//   busy                  scheduler not idle
module dht_scheduler #(
  parameter int ADDR_W      = 2,
  parameter int GAP_CYC     = 100_000_000,
  parameter int TIMEOUT_CYC = 2_500_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_cont,
  input  logic                   req_stop,
  output logic [2**ADDR_W-1:0]   dht_en,
  input  logic [2**ADDR_W-1:0]   dht_done,
  input  logic [2**ADDR_W-1:0]   dht_error,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic                   rd_error,
  output logic                   rd_timeout,
  output logic [2**ADDR_W-1:0]   cont_mask,
  output logic                   busy
);

  localparam int N     = 2**ADDR_W;
  localparam int GAP_W = $clog2(GAP_CYC + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    REPORT = 2'd2
  } stateT;

  stateT              state_q, state_d;
  logic [N-1:0]       pendMask_q, pendMask_d;
  logic [N-1:0]       contMask_q, contMask_d;
  logic [GAP_W-1:0]   gapCnt_q [N];
  logic [GAP_W-1:0]   gapCnt_d [N];
  logic [ADDR_W-1:0]  rrPtr_q, rrPtr_d;
  logic [ADDR_W-1:0]  curAddr_q, curAddr_d;
  logic [TMO_W-1:0]   tmoCnt_q, tmoCnt_d;
  logic               rdError_q, rdError_d;
  logic               rdTimeout_q, rdTimeout_d;

  logic [N-1:0]       eligible;
  logic [N-1:0]       candidates;
  logic               grantValid;
  logic [ADDR_W-1:0]  grantAddr;
  logic [ADDR_W-1:0]  searchIdx;

  // Arbitration: pending one-shot work always beats continuous re-reads, and
  // only sensors whose gap has expired may be picked. The round-robin search
  // starts just after the last winner; the final step of the loop wraps back
  // onto rrPtr_q itself so a lone candidate equal to the last winner is still
  // found.
  always_comb begin
    eligible   = '0;
    grantValid = 1'b0;
    grantAddr  = rrPtr_q;
    searchIdx  = rrPtr_q;
    for (int i = 0; i < N; i++) begin
      eligible[i] = (gapCnt_q[i] == '0);
    end
    candidates = ((pendMask_q & eligible) != '0) ? (pendMask_q & eligible)
                                                 : (contMask_q & eligible);
    for (int k = 1; k <= N; k++) begin
      searchIdx = rrPtr_q + ADDR_W'(k);
      if (!grantValid && candidates[searchIdx]) begin
        grantValid = 1'b1;
        grantAddr  = searchIdx;
      end
    end
  end

  // Next-state logic. The FSM's own grant clears the winner's pending bit
  // first, and the request decoder is applied afterwards. A request that lands
  // in the same cycle as a grant, or during the read, therefore re-arms the
  // sensor for another read after its gap.
  always_comb begin
    state_d     = state_q;
    pendMask_d  = pendMask_q;
    contMask_d  = contMask_q;
    rrPtr_d     = rrPtr_q;
    curAddr_d   = curAddr_q;
    tmoCnt_d    = tmoCnt_q;
    rdError_d   = rdError_q;
    rdTimeout_d = rdTimeout_q;
    for (int i = 0; i < N; i++) begin
      gapCnt_d[i] = (gapCnt_q[i] != '0) ? gapCnt_q[i] - 1'b1 : '0;
    end

    case (state_q)
      IDLE: begin
        if (grantValid) begin
          state_d               = READ;
          curAddr_d             = grantAddr;
          rrPtr_d               = grantAddr;
          pendMask_d[grantAddr] = 1'b0;
          tmoCnt_d              = '0;
        end
      end
      READ: begin
        tmoCnt_d = tmoCnt_q + 1'b1;
        if (dht_done[curAddr_q]) begin
          rdError_d           = dht_error[curAddr_q];
          rdTimeout_d         = 1'b0;
          gapCnt_d[curAddr_q] = GAP_W'(GAP_CYC);
          state_d             = REPORT;
        end else if (tmoCnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          rdError_d           = 1'b1;
          rdTimeout_d         = 1'b1;
          gapCnt_d[curAddr_q] = GAP_W'(GAP_CYC);
          state_d             = REPORT;
        end
      end
      REPORT: begin
        if (rd_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (req_valid) begin
      if (req_stop) begin
        pendMask_d[req_addr] = 1'b0;
        contMask_d[req_addr] = 1'b0;
      end else begin
        pendMask_d[req_addr] = 1'b1;
        if (req_cont) begin
          contMask_d[req_addr] = 1'b1;
        end
      end
    end
  end

  // State registers. After reset every gap counter starts full so freshly
  // powered sensors get their settling time before the first read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pendMask_q  <= '0;
      contMask_q  <= '0;
      rrPtr_q     <= '1;
      curAddr_q   <= '0;
      tmoCnt_q    <= '0;
      rdError_q   <= 1'b0;
      rdTimeout_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        gapCnt_q[i] <= GAP_W'(GAP_CYC);
      end
    end else begin
      state_q     <= state_d;
      pendMask_q  <= pendMask_d;
      contMask_q  <= contMask_d;
      rrPtr_q     <= rrPtr_d;
      curAddr_q   <= curAddr_d;
      tmoCnt_q    <= tmoCnt_d;
      rdError_q   <= rdError_d;
      rdTimeout_q <= rdTimeout_d;
      for (int i = 0; i < N; i++) begin
        gapCnt_q[i] <= gapCnt_d[i];
      end
    end
  end

  // Outputs decode straight from registered state. The enable exists only in
  // READ, so moving through REPORT guarantees a low cycle between reads.
  always_comb begin
    dht_en = '0;
    if (state_q == READ) begin
      dht_en[curAddr_q] = 1'b1;
    end
  end

  assign rd_valid   = (state_q == REPORT);
  assign rd_addr    = curAddr_q;
  assign rd_error   = rdError_q;
  assign rd_timeout = rdTimeout_q;
  assign cont_mask  = contMask_q;
  assign busy       = (state_q != IDLE);

endmodule
